// File: rtl/weight_loader_pkg.sv
// Shared types and constants for the conv weight loader.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package weight_loader_pkg;

  // Stream and weight-bus widths.
  localparam int STREAM_W = 32;
  localparam int ENTRY_W  = 16;
  localparam int ADDR_W   = 32;

  // Header word positions within a packet; payload starts after HDR_WORDS.
  localparam int HDR_ADDR_IDX = 0;
  localparam int HDR_LEN_IDX  = 1;
  localparam int HDR_WORDS    = 2;

  typedef enum logic [2:0] {
    S_ADDR = 3'd0,
    S_LEN  = 3'd1,
    S_LO   = 3'd2,
    S_HI   = 3'd3,
    S_CSUM = 3'd4
  } state_t;

endpackage

// File: rtl/weight_loader.sv
// Converts a 32-bit config stream (addr, len, packed 16-bit pairs) into weight bus writes; optional trailer checksum under WEIGHT_LOADER_CSUM_EN.
// Latency: a write appears 1 cycle after its payload-word transfer; the high-half write follows on the next cycle.
// Backpressure: s_ready drops for one cycle after each payload word while the high half is written; the write port has none.
module weight_loader
  import weight_loader_pkg::*;
#(
  parameter int LEN_WIDTH = 24
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [STREAM_W-1:0] s_data,
  input  logic                s_valid,
  output logic                s_ready,
  output logic [ENTRY_W-1:0]  weight_wr_data,
  output logic [ADDR_W-1:0]   weight_wr_addr,
  output logic                weight_wr_en,
  output logic                busy,
  output logic                load_done,
  output logic                csum_err
);

`ifdef WEIGHT_LOADER_CSUM_EN
  localparam state_t S_END = S_CSUM;
`else
  localparam state_t S_END = S_ADDR;
`endif

  state_t               state, state_nxt;
  logic [ADDR_W-1:0]    next_addr;
  logic [LEN_WIDTH-1:0] remaining;
  logic [ENTRY_W-1:0]   hi_dat;

  logic                 addr_cap;
  logic                 len_cap;
  logic                 hi_cap;
  logic                 wr_go;
  logic                 done_go;
  logic [ENTRY_W-1:0]   wr_val;
  logic                 last_entry;
`ifdef WEIGHT_LOADER_CSUM_EN
  logic                 chk_go;
  logic [ENTRY_W-1:0]   csum;
`endif

  assign last_entry = (remaining == LEN_WIDTH'(1));
  assign busy       = (state != S_ADDR);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_ADDR;
    else     state <= state_nxt;
  end

  // Next state and per-cycle datapath controls; s_ready depends on state only.
  always_comb begin
    state_nxt = state;
    s_ready   = 1'b0;
    addr_cap  = 1'b0;
    len_cap   = 1'b0;
    hi_cap    = 1'b0;
    wr_go     = 1'b0;
    done_go   = 1'b0;
    wr_val    = s_data[ENTRY_W-1:0];
`ifdef WEIGHT_LOADER_CSUM_EN
    chk_go    = 1'b0;
`endif
    case (state)
      S_ADDR: begin
        s_ready = 1'b1;
        if (s_valid) begin
          addr_cap  = 1'b1;
          state_nxt = S_LEN;
        end
      end
      S_LEN: begin
        s_ready = 1'b1;
        if (s_valid) begin
          len_cap = 1'b1;
          if (s_data[LEN_WIDTH-1:0] == '0) begin
            done_go   = 1'b1;
            state_nxt = S_END;
          end else begin
            state_nxt = S_LO;
          end
        end
      end
      S_LO: begin
        s_ready = 1'b1;
        if (s_valid) begin
          wr_go = 1'b1;
          if (last_entry) begin
            // Odd count: upper half of the final word is padding.
            done_go   = 1'b1;
            state_nxt = S_END;
          end else begin
            hi_cap    = 1'b1;
            state_nxt = S_HI;
          end
        end
      end
      S_HI: begin
        // Drains the latched upper half regardless of the stream.
        wr_go  = 1'b1;
        wr_val = hi_dat;
        if (last_entry) begin
          done_go   = 1'b1;
          state_nxt = S_END;
        end else begin
          state_nxt = S_LO;
        end
      end
`ifdef WEIGHT_LOADER_CSUM_EN
      S_CSUM: begin
        s_ready = 1'b1;
        if (s_valid) begin
          chk_go    = 1'b1;
          state_nxt = S_ADDR;
        end
      end
`endif
      default: state_nxt = S_ADDR;
    endcase
  end

  // Address/count tracking, half-word latch and registered write port.
  always_ff @(posedge clk) begin
    if (rst) begin
      next_addr      <= '0;
      remaining      <= '0;
      hi_dat         <= '0;
      weight_wr_en   <= 1'b0;
      weight_wr_data <= '0;
      weight_wr_addr <= '0;
      load_done      <= 1'b0;
    end else begin
      weight_wr_en <= wr_go;
      load_done    <= done_go;
      if (addr_cap) next_addr <= s_data;
      if (len_cap)  remaining <= s_data[LEN_WIDTH-1:0];
      if (hi_cap)   hi_dat    <= s_data[STREAM_W-1:ENTRY_W];
      if (wr_go) begin
        weight_wr_data <= wr_val;
        weight_wr_addr <= next_addr;
        next_addr      <= next_addr + ADDR_W'(1);
        remaining      <= remaining - LEN_WIDTH'(1);
      end
    end
  end

`ifdef WEIGHT_LOADER_CSUM_EN
  // Running mod-2^16 sum of written entries, compared against the trailer word.
  always_ff @(posedge clk) begin
    if (rst) begin
      csum     <= '0;
      csum_err <= 1'b0;
    end else begin
      csum_err <= chk_go && (s_data[ENTRY_W-1:0] != csum);
      if (state == S_ADDR) csum <= '0;
      else if (wr_go)      csum <= csum + wr_val;
    end
  end
`else
  assign csum_err = 1'b0;
`endif

endmodule

// File: tb/tb_weight_loader.sv
`timescale 1ns/1ps
module tb_weight_loader;

`ifdef WEIGHT_LOADER_CSUM_EN
  localparam bit CSUM = 1'b1;
`else
  localparam bit CSUM = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] s_data;
  logic        s_valid;
  logic        s_ready;
  logic [15:0] weight_wr_data;
  logic [31:0] weight_wr_addr;
  logic        weight_wr_en;
  logic        busy;
  logic        load_done;
  logic        csum_err;

  weight_loader #(.LEN_WIDTH(24)) dut (
    .clk(clk), .rst(rst),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .weight_wr_data(weight_wr_data), .weight_wr_addr(weight_wr_addr),
    .weight_wr_en(weight_wr_en), .busy(busy),
    .load_done(load_done), .csum_err(csum_err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;
  int n_err_total = 0;

  logic [31:0] wa_q[$];
  logic [15:0] wd_q[$];
  int          wc_q[$];
  int          lc_q[$];
  logic        lb_q[$];
  int          ec_q[$];
  logic        rdy_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Observe the write bus and pulses away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (weight_wr_en) begin
        wa_q.push_back(weight_wr_addr);
        wd_q.push_back(weight_wr_data);
        wc_q.push_back(cyc);
      end
      if (load_done) begin
        lc_q.push_back(cyc);
        lb_q.push_back(busy);
      end
      if (csum_err) begin
        ec_q.push_back(cyc);
        n_err_total++;
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_logs();
    wa_q.delete(); wd_q.delete(); wc_q.delete();
    lc_q.delete(); lb_q.delete(); ec_q.delete(); rdy_q.delete();
  endtask

  task automatic idle(input int n);
    s_valid = 1'b0;
    s_data  = 32'hFFFF_FFFF;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Present w after 'gap' idle cycles; returns #1 after the transfer edge.
  task automatic send_word(input logic [31:0] w, input int gap);
    logic r;
    bit   ok;
    ok = 1'b0;
    for (int i = 0; i < gap; i++) begin
      s_valid = 1'b0;
      s_data  = 32'hFFFF_FFFF;
      @(posedge clk); #1;
    end
    s_valid = 1'b1;
    s_data  = w;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      r = s_ready;
      rdy_q.push_back(r);
      @(posedge clk); #1;
      ok = r;
    end
    if (!ok) chk("xfer_timeout", 64'd0, 64'd1);
  endtask

  task automatic send_trailer(input logic [15:0] sum);
`ifdef WEIGHT_LOADER_CSUM_EN
    send_word({16'h0000, sum}, 0);
    idle(2);
`endif
  endtask

  task automatic chk_wr(input string tag, input int idx, input logic [31:0] addr, input logic [15:0] dat);
    if (idx >= wa_q.size()) begin
      chk({tag, "_missing"}, 64'(wa_q.size()), 64'(idx + 1));
    end else begin
      chk({tag, "_addr"}, 64'(wa_q[idx]), 64'(addr));
      chk({tag, "_data"}, 64'(wd_q[idx]), 64'(dat));
    end
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1);
  end

  initial begin
    int t;
    logic [5:0] pat;
    rst = 1'b1; s_valid = 1'b0; s_data = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_wr_en",   64'(weight_wr_en),   64'd0);
    chk("rst_wr_data", 64'(weight_wr_data), 64'd0);
    chk("rst_wr_addr", 64'(weight_wr_addr), 64'd0);
    chk("rst_done",    64'(load_done),      64'd0);
    chk("rst_csum",    64'(csum_err),       64'd0);
    chk("rst_busy",    64'(busy),           64'd0);
    chk("rst_ready",   64'(s_ready),        64'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    idle(1);

    // 1: back-to-back N=4 packet
    clear_logs();
    send_word(32'h0000_4318, 0);
    send_word(32'd4, 0);
    send_word(32'h0002_0001, 0);
    t = cyc;
    send_word(32'h0004_0003, 0);
    @(negedge clk);
    rdy_q.push_back(s_ready);
    s_valid = 1'b0;
    idle(3);
    chk("t1_rdy_cnt", 64'(rdy_q.size()), 64'd6);
    pat = '0;
    for (int i = 0; i < 6 && i < rdy_q.size(); i++) pat[5-i] = rdy_q[i];
    chk("t1_rdy_pat", 64'(pat), 64'b111010);
    chk("t1_nwr", 64'(wa_q.size()), 64'd4);
    chk_wr("t1_w0", 0, 32'h0000_4318, 16'h0001);
    chk_wr("t1_w1", 1, 32'h0000_4319, 16'h0002);
    chk_wr("t1_w2", 2, 32'h0000_431A, 16'h0003);
    chk_wr("t1_w3", 3, 32'h0000_431B, 16'h0004);
    if (wc_q.size() == 4) begin
      chk("t1_lat", 64'(wc_q[0]), 64'(t));
      for (int i = 1; i < 4; i++) chk("t1_consec", 64'(wc_q[i]), 64'(wc_q[0] + i));
    end else chk("t1_wc", 64'(wc_q.size()), 64'd4);
    chk("t1_ndone", 64'(lc_q.size()), 64'd1);
    if (lc_q.size() == 1 && wc_q.size() == 4) begin
      chk("t1_done_cyc", 64'(lc_q[0]), 64'(wc_q[3]));
      chk("t1_busy_end", 64'(lb_q[0]), 64'(CSUM));
    end
    send_trailer(16'h000A);

    // 2: odd count, discarded upper half, then next packet
    clear_logs();
    send_word(32'h0000_0100, 0);
    send_word(32'd3, 0);
    send_word(32'hBBBB_AAAA, 0);
    send_word(32'hDEAD_CCCC, 0);
    idle(3);
    send_trailer(16'h3331);
    send_word(32'h0000_0200, 0);
    send_word(32'hFF00_0001, 0);
    send_word(32'h1234_0055, 0);
    idle(3);
    send_trailer(16'h0055);
    chk("t2_nwr", 64'(wa_q.size()), 64'd4);
    chk_wr("t2_w0", 0, 32'h0000_0100, 16'hAAAA);
    chk_wr("t2_w1", 1, 32'h0000_0101, 16'hBBBB);
    chk_wr("t2_w2", 2, 32'h0000_0102, 16'hCCCC);
    chk_wr("t2_next", 3, 32'h0000_0200, 16'h0055);
    chk("t2_ndone", 64'(lc_q.size()), 64'd2);

    // 3: empty packet, then address wrap
    clear_logs();
    send_word(32'h0000_0300, 0);
    send_word(32'd0, 0);
    t = cyc;
    idle(3);
    chk("t3_nwr0", 64'(wa_q.size()), 64'd0);
    chk("t3_ndone0", 64'(lc_q.size()), 64'd1);
    if (lc_q.size() > 0) chk("t3_done_cyc", 64'(lc_q[0]), 64'(t));
    send_trailer(16'h0000);
    clear_logs();
    send_word(32'hFFFF_FFFF, 0);
    send_word(32'd2, 0);
    send_word(32'h0002_0001, 0);
    idle(3);
    send_trailer(16'h0003);
    chk("t3_nwr", 64'(wa_q.size()), 64'd2);
    chk_wr("t3_wrap0", 0, 32'hFFFF_FFFF, 16'h0001);
    chk_wr("t3_wrap1", 1, 32'h0000_0000, 16'h0002);

    // 4: s_valid gaps, including during the high-half cycle
    clear_logs();
    send_word(32'h0000_0500, 2);
    send_word(32'd4, $urandom_range(0, 2));
    send_word(32'h0002_0001, $urandom_range(0, 2));
    t = cyc;
    send_word(32'h0004_0003, 1 + $urandom_range(0, 2));
    idle(4);
    send_trailer(16'h000A);
    chk("t4_nwr", 64'(wa_q.size()), 64'd4);
    chk_wr("t4_w0", 0, 32'h0000_0500, 16'h0001);
    chk_wr("t4_w1", 1, 32'h0000_0501, 16'h0002);
    chk_wr("t4_w2", 2, 32'h0000_0502, 16'h0003);
    chk_wr("t4_w3", 3, 32'h0000_0503, 16'h0004);
    if (wc_q.size() == 4) begin
      chk("t4_lat", 64'(wc_q[0]), 64'(t));
      chk("t4_hi0", 64'(wc_q[1]), 64'(wc_q[0] + 1));
      chk("t4_hi1", 64'(wc_q[3]), 64'(wc_q[2] + 1));
    end
    chk("t4_ndone", 64'(lc_q.size()), 64'd1);

    // 5: reset mid-packet
    clear_logs();
    send_word(32'h0000_0600, 0);
    send_word(32'd6, 0);
    send_word(32'h0002_0001, 0);
    s_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("t5_wr_en",   64'(weight_wr_en),   64'd0);
    chk("t5_wr_data", 64'(weight_wr_data), 64'd0);
    chk("t5_wr_addr", 64'(weight_wr_addr), 64'd0);
    chk("t5_done",    64'(load_done),      64'd0);
    chk("t5_busy",    64'(busy),           64'd0);
    chk("t5_csum",    64'(csum_err),       64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    clear_logs();
    idle(3);
    chk("t5_stray", 64'(wa_q.size()), 64'd0);
    send_word(32'h0000_0020, 0);
    send_word(32'd2, 0);
    send_word(32'h0BBB_0AAA, 0);
    idle(3);
    send_trailer(16'h1665);
    chk("t5_nwr", 64'(wa_q.size()), 64'd2);
    chk_wr("t5_w0", 0, 32'h0000_0020, 16'h0AAA);
    chk_wr("t5_w1", 1, 32'h0000_0021, 16'h0BBB);

`ifdef WEIGHT_LOADER_CSUM_EN
    // 6: trailer checksum match and mismatch
    clear_logs();
    send_word(32'h0000_0700, 0);
    send_word(32'd2, 0);
    send_word(32'h8001_8000, 0);
    idle(3);
    send_word(32'h0000_0001, 0);
    idle(3);
    chk("t6_good", 64'(ec_q.size()), 64'd0);
    send_word(32'h0000_0700, 0);
    send_word(32'd2, 0);
    send_word(32'h8001_8000, 0);
    idle(3);
    send_word(32'h0000_0002, 0);
    t = cyc;
    idle(3);
    chk("t6_bad_cnt", 64'(ec_q.size()), 64'd1);
    if (ec_q.size() > 0) chk("t6_bad_cyc", 64'(ec_q[0]), 64'(t));
    chk("t6_err_total", 64'(n_err_total), 64'd1);
`else
    chk("csum_tied", 64'(n_err_total), 64'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
